pack_buffer: RTL and testbench
==============================

// Module: pack_buffer
// PURPOSE
//  - FIFO for 128-bit TPIU frames. It sits between the trace-pin front end (traceIF) and the output handler.
//  - Captures each new Packet announced by a PkAvail toggle and stores it in a circular RAM.
//  - Presents the oldest frame on Frame. FrameNext pops it.
//  - Reports the occupancy on FramesCnt and flags dropped frames on DataOverf.
// PARAMETERS
//  - BUFFLENLOG2  default 9  log2 of RAM slots. Usable depth is 2^BUFFLENLOG2-1 frames (one slot always stays empty).
// PORTS
//  - clk        in   1            system clock; single clock domain for all logic
//  - rst        in   1            reset, asynchronous, active-low
//  - PkAvail    in   1            toggles once per new packet; may come from the trace clock domain
//  - Packet     in   128          latest packet; stable for at least 4 clk after a PkAvail toggle
//  - Frame      out  128          oldest stored frame; valid while FramesCnt!=0
//  - FrameNext  in   1            one-cycle pop strobe
//  - FramesCnt  out  BUFFLENLOG2  number of frames held
//  - DataOverf  out  1            a frame was dropped because the buffer was full
// BEHAVIOUR
//  - Reset (rst=0, async):
//    - wrptr=rdptr=0; FramesCnt=0; DataOverf=0; Frame=0.
//    - Edge detector: pkLast=PkAvail after sync, so there is no spurious write on release.
//  - Packet detect:
//    - A write request pulses for 1 clk whenever the (synced) PkAvail differs from pkLast; pkLast is then updated.
//    - Packet is sampled in that same cycle.
//  - Write:
//    - Not full (FramesCnt != 2^BUFFLENLOG2-1): RAM[wrptr]<=Packet; wrptr++ (mod 2^BUFFLENLOG2).
//    - Full: packet discarded; pointers unchanged; DataOverf<=1.
//  - Read:
//    - FrameNext=1 and FramesCnt!=0: rdptr++ (mod 2^BUFFLENLOG2).
//    - FrameNext while empty is ignored; no underflow.
//  - Frame:
//    - Registered RAM read of rdptr. It updates on the clk edge after any pointer or count change, so a consumer
//      may pop again 2 cycles after a prior pop.
//    - Frame written into an empty buffer is visible on Frame the cycle after FramesCnt becomes 1.
//  - FramesCnt = wrptr - rdptr (mod 2^BUFFLENLOG2), registered and updated on the same edge as the pointers.
//  - Simultaneous write and pop: both happen; FramesCnt unchanged.
//    - When full, a pop in the same cycle does NOT make room: the write is still judged against the pre-edge count
//      and is dropped.
//  - DataOverf is sticky. It clears only when FramesCnt reaches 0 through pops, or on reset.
//  - Pointer wrap: the pointers roll over from 2^BUFFLENLOG2-1 to 0 with no other effect.
//  - Data ordering: strictly FIFO. No frame is duplicated or reordered.
// CONFIGURATION
//  - PKAVAIL_SYNC_EN defined:
//    - PkAvail passes through a 2-FF synchroniser before edge detection.
//    - Toggle-to-FramesCnt latency is 4 clk.
//    - Packet is sampled at the detect cycle and must still be stable then.
//  - PKAVAIL_SYNC_EN undefined:
//    - PkAvail is taken as synchronous to clk and registered once for edge detection.
//    - Toggle-to-FramesCnt latency is 2 clk.
//  - All other behaviour is identical in both builds.
// TESTING
//  - Reset:
//    - Pulse rst low mid-operation with 3 frames held -> FramesCnt=0, DataOverf=0, Frame=0 immediately.
//    - No write on release even if PkAvail=1.
//  - Single frame:
//    - Toggle PkAvail with Packet=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> FramesCnt=1 within the latency.
//    - Frame equals that value; a FrameNext pulse -> FramesCnt=0.
//  - FIFO order:
//    - Write frames with values 1..10 at one toggle per 8 clk; pop each when FramesCnt!=0 with 1 idle cycle between pops.
//    - Frames read are 1..10 in order; FramesCnt ends at 0.
//  - Full/overflow (BUFFLENLOG2=3):
//    - Write 8 frames with no pops -> FramesCnt=7; DataOverf=1; frame 8 lost.
//    - Pop 7 -> values 1..7 returned; DataOverf=0 once FramesCnt=0.
//  - Wrap and simultaneous (BUFFLENLOG2=3):
//    - Run 20 frames with a pop landing in the same cycle as each write detect -> FramesCnt stays 1 and order is preserved.
//  - Underflow: FrameNext pulses while empty -> FramesCnt stays 0 and the pointers do not move.

Source files
------------

// File: rtl/pack_buffer.sv
// pack_buffer: circular FIFO for 128-bit TPIU frames between the trace-pin
// front end and the output handler. A toggle on i_pkAvail announces a new
// packet on i_packet; each one is stored in RAM and the oldest frame is shown
// on o_frame until i_frameNext pops it. One RAM slot always stays empty, so
// usable depth is 2^BUFFLENLOG2-1 frames.
//
// Build option: define PKAVAIL_SYNC_EN when i_pkAvail comes from another clock
// domain. It adds a 2-FF synchroniser in front of the edge detector, and the
// toggle-to-o_framesCnt latency grows from 2 to 4 clocks.
module pack_buffer #(
    parameter int BUFFLENLOG2 = 9
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_pkAvail,
    input  logic [127:0]           i_packet,
    output logic [127:0]           o_frame,
    input  logic                   i_frameNext,
    output logic [BUFFLENLOG2-1:0] o_framesCnt,
    output logic                   o_dataOverf
);

    localparam int DEPTH = 1 << BUFFLENLOG2;
    localparam logic [BUFFLENLOG2-1:0] PTR_ONE = BUFFLENLOG2'(1);
    localparam logic [BUFFLENLOG2-1:0] CNT_MAX = '1;

    // The edge detector has to ignore the first samples after reset, until
    // the synchronised toggle level is valid. Otherwise a toggle line that is
    // already high when reset is released would look like a new packet.
`ifdef PKAVAIL_SYNC_EN
    localparam logic [1:0] ARM_CYCLES = 2'd3;
`else
    localparam logic [1:0] ARM_CYCLES = 2'd1;
`endif

    logic                   w_pkSync;
    logic                   r_pkLast;
    logic [1:0]             r_armCnt;
    logic                   r_wrReq;
    logic [127:0]           r_packet;

    logic [127:0]           r_ram [0:DEPTH-1];
    logic [BUFFLENLOG2-1:0] r_wrPtr;
    logic [BUFFLENLOG2-1:0] r_rdPtr;
    logic [BUFFLENLOG2-1:0] r_cnt;
    logic                   r_overf;
    logic [127:0]           r_frame;

    logic                   w_full;
    logic                   w_doWrite;
    logic                   w_drop;
    logic                   w_doRead;

`ifdef PKAVAIL_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchroniser that brings the toggle line into the clk domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pkAvail;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pkSync = r_sync2;
`else
    assign w_pkSync = i_pkAvail;
`endif

    // Toggle detector. It compares against the last seen level, registers a
    // one-cycle write request, and captures the packet in the detect cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pkLast <= 1'b0;
            r_armCnt <= ARM_CYCLES;
            r_wrReq  <= 1'b0;
            r_packet <= '0;
        end else if (r_armCnt != 2'd0) begin
            r_armCnt <= r_armCnt - 2'd1;
            r_pkLast <= w_pkSync;
            r_wrReq  <= 1'b0;
        end else begin
            r_wrReq  <= w_pkSync ^ r_pkLast;
            r_pkLast <= w_pkSync;
            if (w_pkSync != r_pkLast) begin
                r_packet <= i_packet;
            end
        end
    end

    // Fullness is judged on the pre-edge count, so a pop in the same cycle
    // cannot make room for a write to a full buffer.
    assign w_full    = (r_cnt == CNT_MAX);
    assign w_doWrite = r_wrReq & ~w_full;
    assign w_drop    = r_wrReq & w_full;
    assign w_doRead  = i_frameNext & (r_cnt != '0);

    // Frame storage. It has no reset, so it can map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (w_doWrite) begin
            r_ram[r_wrPtr] <= r_packet;
        end
    end

    // Pointer and occupancy bookkeeping. The pointers wrap naturally at the
    // RAM size, and the count moves only on an unbalanced write or pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_doWrite) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_doRead) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_doWrite, w_doRead})
                2'b10:   r_cnt <= r_cnt + PTR_ONE;
                2'b01:   r_cnt <= r_cnt - PTR_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky overflow flag. It is set by any dropped packet and cleared only
    // when the consumer drains the buffer to empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overf <= 1'b0;
        end else if (w_drop) begin
            r_overf <= 1'b1;
        end else if (w_doRead && !w_doWrite && (r_cnt == PTR_ONE)) begin
            r_overf <= 1'b0;
        end
    end

    // Registered read of the oldest slot. It trails pointer changes by one
    // clock, which is why back-to-back pops need a gap cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame <= '0;
        end else begin
            r_frame <= r_ram[r_rdPtr];
        end
    end

    assign o_frame     = r_frame;
    assign o_framesCnt = r_cnt;
    assign o_dataOverf = r_overf;

endmodule

// File: tb/tb_pack_buffer.sv
// Self-checking bench for pack_buffer (small BUFFLENLOG2=3 instance).
// The reference model is a queue of frames plus a list of announced packets,
// each tagged with the clock edge where it should land. The monitor keeps the
// model in step and compares the count, the overflow flag and every popped
// frame against it.
module tb_pack_buffer;

    localparam int N    = 3;
    localparam int MAXF = (1 << N) - 1;
`ifdef PKAVAIL_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif
    localparam logic [127:0] SINGLE = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    typedef struct {
        logic [127:0] data;
        int           land;
    } pend_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           pkAvail;
    logic [127:0]   packet;
    logic [127:0]   frame;
    logic           frameNext;
    logic [N-1:0]   framesCnt;
    logic           dataOverf;

    int             checks = 0;
    int             failures = 0;
    int             cycle = 0;
    int             framesPopped = 0;
    int             lastPopEdge = -100;
    bit             prevNonzero = 1'b0;
    bit             modelOverf = 1'b0;
    logic [127:0]   expQ[$];
    pend_t          pendQ[$];

    pack_buffer #(.BUFFLENLOG2(N)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pkAvail   (pkAvail),
        .i_packet    (packet),
        .o_frame     (frame),
        .i_frameNext (frameNext),
        .o_framesCnt (framesCnt),
        .o_dataOverf (dataOverf)
    );

    always #5 clk = ~clk;

    // One comparison: count it, and report any difference.
    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one clock's worth of inputs and record what the model should expect.
    task automatic applyStimulus(input bit doToggle, input logic [127:0] value, input bit doPop);
        pend_t p;
        if (doToggle) begin
            packet  = value;
            pkAvail = ~pkAvail;
            p.data  = value;
            p.land  = cycle + LAT;
            pendQ.push_back(p);
        end
        frameNext = doPop;
        if (doPop) begin
            lastPopEdge = cycle + 1;
        end
        prevNonzero = (framesCnt != '0);
        @(posedge clk);
        #2;
        frameNext = 1'b0;
    endtask

    // Consumer rule: the buffer must be non-empty now and at the previous
    // decision, and the last pop must be at least two edges back.
    function automatic bit canPop();
        return (framesCnt != '0) && prevNonzero && ((cycle + 1 - lastPopEdge) >= 2);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, 1'b0);
        end
    endtask

    function automatic logic [127:0] randFrame();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor and model: compare at the falling edge, advance at the rising edge.
    initial begin : monitor
        bit           popNow;
        int           preSize;
        logic [127:0] popped;
        pend_t        p;
        forever begin
            @(negedge clk);
            popNow = 1'b0;
            if (!rst_n) begin
                expQ.delete();
                pendQ.delete();
                modelOverf = 1'b0;
            end else begin
                checkOutput("framesCnt", 128'(framesCnt), 128'(expQ.size()));
                checkOutput("dataOverf", 128'(dataOverf), 128'(modelOverf));
                popNow = frameNext && (expQ.size() != 0);
                if (popNow) begin
                    checkOutput("poppedFrame", frame, expQ[0]);
                    framesPopped++;
                end
            end
            @(posedge clk);
            cycle++;
            if (rst_n) begin
                preSize = expQ.size();
                if (pendQ.size() != 0 && pendQ[0].land == cycle) begin
                    p = pendQ.pop_front();
                    if (preSize == MAXF) begin
                        modelOverf = 1'b1;
                    end else begin
                        expQ.push_back(p.data);
                    end
                end
                if (popNow) begin
                    popped = expQ.pop_front();
                    if (expQ.size() == 0) begin
                        modelOverf = 1'b0;
                    end
                end
            end
        end
    end

    // Safety net so the run always ends.
    initial begin : watchdog
        #400000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stimulus
        int startPops;
        int lastToggle;
        rst_n     = 1'b0;
        pkAvail   = 1'b0;
        packet    = '0;
        frameNext = 1'b0;
        #1;
        checkOutput("resetCnt", 128'(framesCnt), 128'd0);
        checkOutput("resetOverf", 128'(dataOverf), 128'd0);
        checkOutput("resetFrame", frame, 128'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(6);

        // A single frame goes in and comes back out.
        $display("[TB] single frame");
        applyStimulus(1'b1, SINGLE, 1'b0);
        idle(LAT - 1);
        checkOutput("singleCnt", 128'(framesCnt), 128'd1);
        idle(1);
        checkOutput("singleFrame", frame, SINGLE);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("singlePoppedCnt", 128'(framesCnt), 128'd0);
        idle(4);

        // FIFO order: values 1..10, one toggle every 8 clocks, pops as allowed.
        $display("[TB] fifo order");
        startPops = framesPopped;
        for (int i = 0; i < 80; i++) begin
            applyStimulus((i % 8) == 0, 128'(i / 8 + 1), canPop());
        end
        for (int i = 0; i < 60 && framesCnt != '0; i++) begin
            applyStimulus(1'b0, '0, canPop());
        end
        idle(2);
        checkOutput("orderCount", 128'(framesPopped - startPops), 128'd10);
        checkOutput("orderEndCnt", 128'(framesCnt), 128'd0);

        // Pops while empty must be ignored; a later frame must still come out right.
        $display("[TB] underflow");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            idle(1);
        end
        checkOutput("underflowCnt", 128'(framesCnt), 128'd0);
        startPops = framesPopped;
        applyStimulus(1'b1, randFrame(), 1'b0);
        idle(LAT + 1);
        for (int i = 0; i < 10 && framesCnt != '0; i++) begin
            applyStimulus(1'b0, '0, canPop());
        end
        checkOutput("underflowPop", 128'(framesPopped - startPops), 128'd1);

        // Full: eight writes with no pops; the eighth is dropped.
        $display("[TB] full and overflow");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 128'(i + 1), 1'b0);
            idle(3);
        end
        idle(LAT + 2);
        checkOutput("fullCnt", 128'(framesCnt), 128'd7);
        checkOutput("fullOverf", 128'(dataOverf), 128'd1);
        startPops = framesPopped;
        for (int i = 0; i < 40 && framesCnt != '0; i++) begin
            applyStimulus(1'b0, '0, canPop());
        end
        idle(2);
        checkOutput("drainCount", 128'(framesPopped - startPops), 128'd7);
        checkOutput("drainOverf", 128'(dataOverf), 128'd0);

        // Wrap, with a pop on the same edge as each write.
        $display("[TB] wrap with simultaneous pop");
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < 4; k++) begin
                applyStimulus(k == 0, randFrame(), (k == LAT - 1) && (it > 0));
            end
        end
        checkOutput("wrapCnt", 128'(framesCnt), 128'd1);
        applyStimulus(1'b0, '0, 1'b1);
        idle(2);
        checkOutput("wrapEndCnt", 128'(framesCnt), 128'd0);

        // Random soak: random toggles and pops, against the model.
        $display("[TB] random soak");
        lastToggle = -10;
        for (int i = 0; i < 400; i++) begin
            bit tg;
            tg = ((i - lastToggle) >= 4) && ($urandom_range(2) == 0);
            if (tg) begin
                lastToggle = i;
            end
            applyStimulus(tg, randFrame(), canPop() && ($urandom_range(1) == 0));
        end
        idle(LAT + 2);

        // Reset in mid-operation with three frames held.
        $display("[TB] reset mid-operation");
        for (int i = 0; i < 40 && framesCnt != '0; i++) begin
            applyStimulus(1'b0, '0, canPop());
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, randFrame(), 1'b0);
            idle(3);
        end
        idle(LAT);
        checkOutput("preResetCnt", 128'(framesCnt), 128'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetCnt", 128'(framesCnt), 128'd0);
        checkOutput("midResetOverf", 128'(dataOverf), 128'd0);
        checkOutput("midResetFrame", frame, 128'd0);
        pkAvail = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(8);
        checkOutput("releaseNoWrite", 128'(framesCnt), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
